// File: rtl/b_bop_arb_pkg.sv
// Shared constants, FSM encoding and helpers for the b_bop round-robin arbiter.
package b_bop_arb_pkg;

  localparam int DATA_W   = 32;
  localparam int LUT_W    = 8;
  localparam int NREQ_DEF = 2;
  localparam int NREQ_MAX = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic logic [DATA_W-1:0] slice_word(input logic [NREQ_MAX*DATA_W-1:0] bus,
                                                   input int idx);
    return bus[idx*DATA_W +: DATA_W];
  endfunction

  function automatic logic [LUT_W-1:0] slice_lut(input logic [NREQ_MAX*LUT_W-1:0] bus,
                                                 input int idx);
    return bus[idx*LUT_W +: LUT_W];
  endfunction

  // One-hot pick of the first valid requester at or after ptr, wrapping modulo n.
  function automatic logic [NREQ_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                                  input logic [2:0] ptr,
                                                  input int n);
    logic [NREQ_MAX-1:0] grant;
    logic found;
    int idx;
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < NREQ_MAX; off++) begin
      idx = (int'(ptr) + off) % n;
      if (off < n && !found && valid[idx[2:0]]) begin
        grant[idx[2:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/b_bop.sv
// Bit-wise ternary LUT: each result bit indexes lut with {rd, rs1, rs2} at that position.
module b_bop
  import b_bop_arb_pkg::*;
(
  input  logic [DATA_W-1:0] rd,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic [LUT_W-1:0]  lut,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    for (int k = 0; k < DATA_W; k++) begin
      result[k] = lut[{rd[k], rs1[k], rs2[k]}];
    end
  end

endmodule

// File: rtl/b_bop_arb.sv
// Round-robin arbiter sharing one b_bop datapath between NREQ requesters,
// with a one-entry output register that can drain and refill in the same cycle.
module b_bop_arb
  import b_bop_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_rd,
  input  logic [NREQ*DATA_W-1:0] req_rs1,
  input  logic [NREQ*DATA_W-1:0] req_rs2,
  input  logic [NREQ*LUT_W-1:0]  req_lut,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_result
);

  state_e state, state_next;

  logic [IDW-1:0]             out_id, rr_ptr, grant_id;
  logic [DATA_W-1:0]          out_result, bop_result;
  logic [DATA_W-1:0]          sel_rd, sel_rs1, sel_rs2;
  logic [LUT_W-1:0]           sel_lut;
  logic [NREQ_MAX*DATA_W-1:0] rd_ext, rs1_ext, rs2_ext;
  logic [NREQ_MAX*LUT_W-1:0]  lut_ext;
  logic [NREQ_MAX-1:0]        valid_ext, grant_ext;
  logic [2:0]                 ptr_ext;
  logic [NREQ-1:0]            grant;
  logic                       out_full, drain, can_accept, accept;

  // Widen the flattened buses to the package's fixed maximum so the helpers stay generic.
  always_comb begin
    rd_ext    = '0;
    rs1_ext   = '0;
    rs2_ext   = '0;
    lut_ext   = '0;
    valid_ext = '0;
    ptr_ext   = '0;
    rd_ext[NREQ*DATA_W-1:0]  = req_rd;
    rs1_ext[NREQ*DATA_W-1:0] = req_rs1;
    rs2_ext[NREQ*DATA_W-1:0] = req_rs2;
    lut_ext[NREQ*LUT_W-1:0]  = req_lut;
    valid_ext[NREQ-1:0]      = req_valid;
    ptr_ext[IDW-1:0]         = rr_ptr;
  end

  assign grant_ext = rr_pick(valid_ext, ptr_ext, NREQ);
  assign grant     = grant_ext[NREQ-1:0];

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

  assign sel_rd  = slice_word(rd_ext, int'(grant_id));
  assign sel_rs1 = slice_word(rs1_ext, int'(grant_id));
  assign sel_rs2 = slice_word(rs2_ext, int'(grant_id));
  assign sel_lut = slice_lut(lut_ext, int'(grant_id));

  b_bop u_bop (
    .rd     (sel_rd),
    .rs1    (sel_rs1),
    .rs2    (sel_rs2),
    .lut    (sel_lut),
    .result (bop_result)
  );

  // Reset also masks the ready path so nothing appears accepted while it is held.
  assign out_full   = (state == FULL);
  assign drain      = out_full & rsp_ready[out_id];
  assign can_accept = (~out_full | drain) & ~reset;
  assign accept     = (|grant) & can_accept;
  assign req_ready  = grant & {NREQ{can_accept}};

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (accept) state_next = FULL;
               else if (drain) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_result <= '0;
      out_id     <= '0;
      rr_ptr     <= '0;
    end else if (accept) begin
      out_result <= bop_result;
      out_id     <= grant_id;
      rr_ptr     <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = out_full & (out_id == IDW'(i));
    end
  end

  assign rsp_result = out_result;

endmodule

// File: tb/tb_b_bop_arb.sv
// Self-checking bench for b_bop_arb: fixed vectors, hand sequences and a randomized model run.
module tb_b_bop_arb;
  import b_bop_arb_pkg::*;

  localparam int NREQ = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*32-1:0] req_rd, req_rs1, req_rs2;
  logic [NREQ*8-1:0] req_lut;
  logic [31:0]       rsp_result;

  int compared = 0;
  int mismatched = 0;

  b_bop_arb #(.NREQ(NREQ)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_lut    (req_lut),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          who;
    logic [31:0] rd, rs1, rs2;
    logic [7:0]  lut;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[7];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int who, input logic v, input logic [31:0] rd,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [7:0] lut);
    req_valid[who]          = v;
    req_rd[who*32 +: 32]    = rd;
    req_rs1[who*32 +: 32]   = rs1;
    req_rs2[who*32 +: 32]   = rs2;
    req_lut[who*8 +: 8]     = lut;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] bop_model(input logic [31:0] rd, input logic [31:0] rs1,
                                            input logic [31:0] rs2, input logic [7:0] lut);
    logic [31:0] r;
    int idx;
    for (int k = 0; k < 32; k++) begin
      idx  = 4 * int'(rd[k]) + 2 * int'(rs1[k]) + int'(rs2[k]);
      r[k] = lut[idx];
    end
    return r;
  endfunction

  // Random-phase model state and held requests
  logic        m_full, m_drain;
  int          m_id, m_ptr, g;
  logic [31:0] m_result;
  logic [1:0]  exp_ready, exp_valid;
  logic        pend_v[NREQ];
  logic [31:0] pend_rd[NREQ], pend_rs1[NREQ], pend_rs2[NREQ];
  logic [7:0]  pend_lut[NREQ];
  int          acc[NREQ];
  int          cycles;

  initial begin
    vecs[0] = '{0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h00000000, 8'h96, 32'hF0F00F0F};
    vecs[1] = '{1, 32'hFF00FF00, 32'hF0F0F0F0, 32'hCCCCCCCC, 8'hE8, 32'hFCC0FCC0};
    vecs[2] = '{0, 32'h12345678, 32'h00000000, 32'h00000000, 8'hF0, 32'h12345678};
    vecs[3] = '{1, 32'h00000000, 32'h9ABCDEF0, 32'h00000000, 8'hCC, 32'h9ABCDEF0};
    vecs[4] = '{0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F1234, 8'hAA, 32'h0F0F1234};
    vecs[5] = '{1, 32'hDEADBEEF, 32'hCAFEBABE, 32'h01234567, 8'h00, 32'h00000000};
    vecs[6] = '{0, 32'h00000001, 32'h00000002, 32'h00000003, 8'hFF, 32'hFFFFFFFF};

    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = '0;
    req_rd    = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    req_lut   = '0;
    repeat (2) @(negedge clock);
    #1;
    check_output("reset_req_ready", 32'(req_ready), 32'h0);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("reset_rsp_result", rsp_result, 32'h0);
    req_valid = '0;
    @(negedge clock);
    reset = 1'b0;

    // Single-transaction vectors: accept, observe next cycle, then drain
    for (int v = 0; v < 7; v++) begin
      @(negedge clock);
      rsp_ready = '0;
      apply_stimulus(vecs[v].who, 1'b1, vecs[v].rd, vecs[v].rs1, vecs[v].rs2, vecs[v].lut);
      #1;
      check_output($sformatf("vec%0d_req_ready", v), 32'(req_ready), 32'(1 << vecs[v].who));
      @(negedge clock);
      req_valid = '0;
      #1;
      check_output($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'(1 << vecs[v].who));
      check_output($sformatf("vec%0d_rsp_result", v), rsp_result, vecs[v].expected);
      rsp_ready = '1;
      @(negedge clock);
      #1;
      check_output($sformatf("vec%0d_drained", v), 32'(rsp_valid), 32'h0);
      rsp_ready = '0;
    end

    // Contention with continuous drain: strict alternation, no idle cycle
    do_reset();
    apply_stimulus(0, 1'b1, 32'h12345678, 32'h0, 32'h0, 8'hF0);
    apply_stimulus(1, 1'b1, 32'h0, 32'h9ABCDEF0, 32'h0, 8'hCC);
    rsp_ready = 2'b11;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_output($sformatf("cont%0d_req_ready", c), 32'(req_ready),
                   (c % 2 == 0) ? 32'h1 : 32'h2);
      if (c > 0) begin
        check_output($sformatf("cont%0d_rsp_valid", c), 32'(rsp_valid),
                     (c % 2 == 1) ? 32'h1 : 32'h2);
        check_output($sformatf("cont%0d_rsp_result", c), rsp_result,
                     (c % 2 == 1) ? 32'h12345678 : 32'h9ABCDEF0);
      end
      @(negedge clock);
    end

    // Backpressure on owner 0 while requester 1 waits
    do_reset();
    req_valid = '0;
    rsp_ready = '0;
    apply_stimulus(0, 1'b1, 32'h12345678, 32'h0, 32'h0, 8'hF0);
    #1;
    check_output("bp_first_accept", 32'(req_ready), 32'h1);
    @(negedge clock);
    req_valid[0] = 1'b0;
    apply_stimulus(1, 1'b1, 32'h0, 32'h9ABCDEF0, 32'h0, 8'hCC);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_output($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'h0);
      check_output($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid), 32'h1);
      check_output($sformatf("bp%0d_rsp_result", c), rsp_result, 32'h12345678);
      @(negedge clock);
    end
    rsp_ready = 2'b01;
    #1;
    check_output("bp_release_req_ready", 32'(req_ready), 32'h2);
    @(negedge clock);
    req_valid = '0;
    rsp_ready = '0;
    #1;
    check_output("bp_next_rsp_valid", 32'(rsp_valid), 32'h2);
    check_output("bp_next_rsp_result", rsp_result, 32'h9ABCDEF0);

    // Asynchronous reset while FULL, then pointer restarts at requester 0
    req_valid = 2'b11;
    #1;
    reset = 1'b1;
    #1;
    check_output("async_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("async_rst_req_ready", 32'(req_ready), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_output("post_rst_grant", 32'(req_ready), 32'h1);
    @(negedge clock);
    #1;
    check_output("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
    check_output("post_rst_rsp_result", rsp_result, 32'h12345678);

    // Randomized traffic against the arbitration model
    do_reset();
    m_full = 1'b0; m_id = 0; m_ptr = 0; m_result = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0;
      acc[i]    = 0;
    end
    cycles = 0;
    while ((acc[0] < 100 || acc[1] < 100) && cycles < 4000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend_v[i] && $urandom_range(3) != 0) begin
          pend_v[i]   = 1'b1;
          pend_rd[i]  = $urandom;
          pend_rs1[i] = $urandom;
          pend_rs2[i] = $urandom;
          case ($urandom_range(3))
            0:       pend_lut[i] = 8'hAA;
            1:       pend_lut[i] = 8'h00;
            2:       pend_lut[i] = 8'hFF;
            default: pend_lut[i] = 8'($urandom);
          endcase
        end
        apply_stimulus(i, pend_v[i], pend_rd[i], pend_rs1[i], pend_rs2[i], pend_lut[i]);
      end
      rsp_ready = 2'($urandom);
      #1;
      g = -1;
      for (int off = 0; off < NREQ; off++) begin
        if (g < 0 && pend_v[(m_ptr + off) % NREQ]) g = (m_ptr + off) % NREQ;
      end
      m_drain   = m_full && rsp_ready[m_id];
      exp_ready = (g >= 0 && (!m_full || m_drain)) ? 2'(1 << g) : 2'b00;
      exp_valid = m_full ? 2'(1 << m_id) : 2'b00;
      check_output("rand_req_ready", 32'(req_ready), 32'(exp_ready));
      check_output("rand_rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (m_full) check_output("rand_rsp_result", rsp_result, m_result);
      @(posedge clock);
      if (exp_ready != 2'b00) begin
        m_result  = bop_model(pend_rd[g], pend_rs1[g], pend_rs2[g], pend_lut[g]);
        m_id      = g;
        m_full    = 1'b1;
        m_ptr     = (g + 1) % NREQ;
        pend_v[g] = 1'b0;
        acc[g]++;
      end else if (m_drain) begin
        m_full = 1'b0;
      end
      cycles++;
      @(negedge clock);
    end
    check_output("rand_completed", 32'(acc[0] >= 100 && acc[1] >= 100), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/b_bop_arb.md
Name: b_bop_arb

Overview:
Round-robin arbiter and sequencer that shares one b_bop ternary-LUT datapath between NREQ independent requesters (e.g. the scalar core port and a coprocessor port).
- Accepts one request per cycle over a valid/ready handshake.
- Evaluates it in a single b_bop instance and holds the result in a one-entry output register until the owning requester accepts it.
- Gives single-cycle latency and full throughput under continuous drain.

Parameters:
NREQ, 2, number of requesters; legal range 2..8.
IDW, clog2(NREQ), width of the internal owner-ID and round-robin pointer.

Ports:
clock  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  NREQ  per-requester request valid.
req_ready  out  NREQ  per-requester request accepted this cycle.
req_rd  in  NREQ*32  flattened rd operands; requester i uses bits [32i+31:32i].
req_rs1  in  NREQ*32  flattened rs1 operands.
req_rs2  in  NREQ*32  flattened rs2 operands.
req_lut  in  NREQ*8  flattened 8-bit truth tables.
rsp_valid  out  NREQ  result available for requester i.
rsp_ready  in  NREQ  requester i consumes the result.
rsp_result  out  32  result data, shared bus; meaningful only where rsp_valid is high.

Behaviour:
- State:
  - out_full (EMPTY/FULL two-state FSM).
  - out_id [IDW].
  - out_result [32].
  - rr_ptr [IDW].
- Reset (asynchronous, any cycle, including mid-transfer): out_full=0, out_id=0, out_result=0, rr_ptr=0. Consequently req_ready=0 and rsp_valid=0 in the reset state; any in-flight result is discarded.
- Grant (combinational): the first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ. At most one grant bit is set; none are set if no request is valid.
- drain = out_full & rsp_ready[out_id].
- can_accept = !out_full | drain. This is a same-cycle pass-through; no bubble.
- req_ready[i] = grant[i] & can_accept.
  - req_ready may depend on other requesters' req_valid.
  - A requester must hold its valid and operands stable until accepted.
- Accept (req_valid[g] & req_ready[g]):
  - out_result <= b_bop(rd_g, rs1_g, rs2_g, lut_g), where bit k = lut[{rd[k], rs1[k], rs2[k]}].
  - out_id <= g.
  - out_full <= 1.
  - rr_ptr <= (g+1) mod NREQ, wrapping from NREQ-1 to 0.
- FSM transitions:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on drain together with accept (back-to-back).
  - FULL -> EMPTY on drain without accept.
  - FULL holds while rsp_ready[out_id]=0.
- rr_ptr is unchanged when no request is accepted. Losers keep priority order, so no starvation: each valid requester is served within NREQ accepts.
- Outputs:
  - rsp_valid[i] = out_full & (out_id==i).
  - rsp_result = out_result, held stable while rsp_valid is high and not drained.
  - rsp_ready of a non-owner is ignored.
- Latency: result visible the cycle after acceptance. Throughput: 1 per cycle when the owner drains in the same cycle.
- The datapath is purely combinational between the operand mux and out_result; no other pipeline stages.

Decomposition:
- Shared package:
  - b_bop_arb_pkg constants: DATA_W=32, LUT_W=8.
  - NREQ default.
  - Flattened-bus slice helper (function returning requester i's field).
  - Round-robin priority-pick function (valid vector, pointer -> one-hot grant).
- Sub-module: instantiate the existing b_bop unchanged, fed by the granted operand mux. No new sub-module is needed.

Test Plan:
- Single request: reset, then req0 with rd=FFFF0000, rs1=0F0F0F0F, rs2=00000000, lut=96 -> req_ready[0]=1 that cycle; next cycle rsp_valid=01, rsp_result=F0F00F0F.
- Majority: req1 with rd=FF00FF00, rs1=F0F0F0F0, rs2=CCCCCCCC, lut=E8 -> rsp_valid=10, rsp_result=FCC0FCC0.
- Contention: both requesters valid continuously with rsp_ready=11; req0 lut=F0 rd=12345678, req1 lut=CC rs1=9ABCDEF0 -> grants alternate 0,1,0,1; results alternate 12345678, 9ABCDEF0 with no idle cycle.
- Backpressure: FULL with out_id=0 and rsp_ready[0]=0 for 3 cycles while req1 is valid -> req_ready=00, rsp_result stable for all 3 cycles; when rsp_ready[0]=1, req1 is accepted in the same cycle and rsp_valid=10 next cycle.
- Reset mid-operation: assert reset asynchronously while FULL -> rsp_valid=00 and req_ready=00 immediately; after release, rr_ptr=0, so with both requesters valid, req0 is granted first.
- Pass-through LUTs: lut=AA returns rs2 exactly; lut=00 gives 00000000; lut=FF gives FFFFFFFF (random operands, 100 transactions per requester) -> every response matches the bit-wise lut[{rd,rs1,rs2}] model and is routed to the correct owner.
